// File: rtl/vga_scan_engine.sv
// VGA scan-timing and pixel-output stage: x/y counters, registered RGB/sync pins and a
// frame_start pulse on the wrap to (0,0). All state advances only on pix_ce.
module vga_scan_engine #(
    parameter int unsigned H_VISIBLE = 800,
    parameter int unsigned H_FRONT   = 56,
    parameter int unsigned H_SYNC    = 120,
    parameter int unsigned H_BACK    = 64,
    parameter int unsigned V_VISIBLE = 600,
    parameter int unsigned V_FRONT   = 37,
    parameter int unsigned V_SYNC    = 6,
    parameter int unsigned V_BACK    = 23,
    parameter bit          HS_POL    = 1'b1,
    parameter bit          VS_POL    = 1'b1,
    parameter logic [8:0]  FG_RGB    = 9'h1FF,
    parameter logic [8:0]  BG_RGB    = 9'h000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_ce,
    input  logic        hit,
    output logic [10:0] x,
    output logic [10:0] y,
    output logic [8:0]  rgb,
    output logic        hsync,
    output logic        vsync,
    output logic        frame_start
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [10:0] HLast    = 11'(H_TOTAL - 1);
    localparam logic [10:0] VLast    = 11'(V_TOTAL - 1);
    localparam logic [10:0] HVis     = 11'(H_VISIBLE);
    localparam logic [10:0] VVis     = 11'(V_VISIBLE);
    localparam logic [10:0] HsFirst  = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] HsLast   = 11'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [10:0] VsFirst  = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] VsLast   = 11'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    logic [10:0] x_q, x_d;
    logic [10:0] y_q, y_d;
    logic [8:0]  rgb_q, rgb_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        frame_start_q, frame_start_d;
    logic        active;

    assign active = (x_q < HVis) && (y_q < VVis);

    always_comb begin
        x_d           = x_q;
        y_d           = y_q;
        rgb_d         = rgb_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        frame_start_d = 1'b0;
        if (pix_ce) begin
            // Pixel outputs are computed from the current counters, so they trail x/y by one.
            rgb_d   = active ? (hit ? FG_RGB : BG_RGB) : 9'h000;
            hsync_d = (x_q >= HsFirst && x_q <= HsLast) ? HS_POL : ~HS_POL;
            vsync_d = (y_q >= VsFirst && y_q <= VsLast) ? VS_POL : ~VS_POL;
            if (x_q == HLast) begin
                x_d = '0;
                if (y_q == VLast) begin
                    y_d           = '0;
                    frame_start_d = 1'b1;
                end else begin
                    y_d = y_q + 11'd1;
                end
            end else begin
                x_d = x_q + 11'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            x_q           <= '0;
            y_q           <= '0;
            rgb_q         <= '0;
            hsync_q       <= ~HS_POL;
            vsync_q       <= ~VS_POL;
            frame_start_q <= 1'b0;
        end else begin
            x_q           <= x_d;
            y_q           <= y_d;
            rgb_q         <= rgb_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign rgb         = rgb_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_scan_engine.sv
// Bench for vga_scan_engine on a shrunken timing (25 x 15 frame) so whole frames fit in a
// short run; a timing model pushes expected outputs per clock and a scoreboard pops them.
module tb_vga_scan_engine;

    localparam int unsigned HV = 16, HF = 3, HS = 4, HB = 2;
    localparam int unsigned VV = 10, VF = 2, VS = 2, VB = 1;
    localparam int unsigned HT = HV + HF + HS + HB;
    localparam int unsigned VT = VV + VF + VS + VB;
    localparam int unsigned FRAME = HT * VT;
    localparam logic [8:0] FG = 9'h1FF;
    localparam logic [8:0] BG = 9'h000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pix_ce = 1'b0;
    logic        hit = 1'b0;
    logic [10:0] x, y;
    logic [8:0]  rgb;
    logic        hsync, vsync, frame_start;

    vga_scan_engine #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .HS_POL(1'b1), .VS_POL(1'b1), .FG_RGB(FG), .BG_RGB(BG)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pix_ce(pix_ce),
        .hit(hit),
        .x(x),
        .y(y),
        .rgb(rgb),
        .hsync(hsync),
        .vsync(vsync),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic [8:0]  rgb;
        logic        hs;
        logic        vs;
        logic        fs;
    } exp_t;

    exp_t sb_q[$];

    int n_tot = 0;
    int n_bad = 0;
    int cyc = 0;

    // Expected DUT state after the most recently modelled edge.
    int          m_x = 0, m_y = 0;
    logic [8:0]  m_rgb = '0;
    logic        m_hs = 1'b0, m_vs = 1'b0, m_fs = 1'b0;

    // Run-length monitors, cleared per phase.
    int hs_cnt = 0, fs_cnt = 0, fg_cnt = 0, fs_first = -1, fs_second = -1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic hit_for(input int mode);
        case (mode)
            1:       return (m_x == 5 && m_y == 3);
            2:       return 1'b1;
            3:       return 1'($urandom_range(0, 1));
            default: return 1'b0;
        endcase
    endfunction

    task automatic clear_mon();
        hs_cnt = 0; fs_cnt = 0; fg_cnt = 0; fs_first = -1; fs_second = -1;
    endtask

    task automatic step(input logic r, input logic ce, input int mode);
        exp_t e;
        logic h;
        @(negedge clk);
        h = hit_for(mode);
        rst = r; pix_ce = ce; hit = h;
        if (!r) begin
            m_x = 0; m_y = 0; m_rgb = '0; m_hs = 1'b0; m_vs = 1'b0; m_fs = 1'b0;
        end else if (ce) begin
            m_rgb = (m_x < HV && m_y < VV) ? (h ? FG : BG) : 9'h000;
            m_hs  = (m_x >= HV + HF) && (m_x < HV + HF + HS);
            m_vs  = (m_y >= VV + VF) && (m_y < VV + VF + VS);
            m_fs  = (m_x == HT - 1) && (m_y == VT - 1);
            if (m_x == HT - 1) begin
                m_x = 0;
                m_y = (m_y == VT - 1) ? 0 : m_y + 1;
            end else begin
                m_x = m_x + 1;
            end
        end else begin
            m_fs = 1'b0;
        end
        e.x = 11'(m_x); e.y = 11'(m_y); e.rgb = m_rgb;
        e.hs = m_hs; e.vs = m_vs; e.fs = m_fs;
        sb_q.push_back(e);

        @(posedge clk);
        #1;
        cyc++;
        e = sb_q.pop_front();
        check("x", 32'(x), 32'(e.x));
        check("y", 32'(y), 32'(e.y));
        check("rgb", 32'(rgb), 32'(e.rgb));
        check("hsync", 32'(hsync), 32'(e.hs));
        check("vsync", 32'(vsync), 32'(e.vs));
        check("frame_start", 32'(frame_start), 32'(e.fs));
        hs_cnt += int'(hsync);
        fg_cnt += int'(rgb == FG);
        if (frame_start) begin
            fs_cnt++;
            if (fs_first < 0) fs_first = cyc;
            else if (fs_second < 0) fs_second = cyc;
        end
    endtask

    initial begin
        // Reset held three clocks with pix_ce high.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 0);
        check("rst_x", 32'(x), 32'd0);
        check("rst_hsync", 32'(hsync), 32'd0);
        check("rst_vsync", 32'(vsync), 32'd0);

        // Free run two frames from (0,0): sync widths and frame_start period.
        clear_mon();
        for (int i = 0; i < 2 * FRAME; i++) step(1'b1, 1'b1, 0);
        check("hs_run_2frames", 32'(hs_cnt), 32'(2 * VT * HS));
        check("fs_count", 32'(fs_cnt), 32'd2);
        check("fs_period", 32'(fs_second - fs_first), 32'(FRAME));

        // Single-pixel hit: exactly one foreground sample per frame.
        clear_mon();
        for (int i = 0; i < FRAME; i++) step(1'b1, 1'b1, 1);
        check("single_hit_fg", 32'(fg_cnt), 32'd1);

        // Constant hit: foreground only over the visible area.
        clear_mon();
        for (int i = 0; i < FRAME; i++) step(1'b1, 1'b1, 2);
        check("const_hit_fg", 32'(fg_cnt), 32'(HV * VV));

        // Alternating pix_ce with random hit: outputs hold on idle clocks.
        for (int i = 0; i < 4 * HT; i++) step(1'b1, 1'(i % 2 == 0), 3);

        // Mid-frame reset, then restart from (0,0) with the first pulse only on wrap.
        for (int i = 0; i < 2 * FRAME && !(m_x == 10 && m_y == 7); i++) step(1'b1, 1'b1, 3);
        check("reached_10_7", 32'(x), 32'd10);
        step(1'b0, 1'b1, 2);
        check("midrst_y", 32'(y), 32'd0);
        check("midrst_rgb", 32'(rgb), 32'd0);
        clear_mon();
        for (int i = 0; i < FRAME - 1; i++) step(1'b1, 1'b1, 3);
        check("no_fs_before_wrap", 32'(fs_cnt), 32'd0);
        step(1'b1, 1'b1, 0);
        check("fs_on_wrap", 32'(frame_start), 32'd1);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
